// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: next-PC select codes and default parameters.
package pc_seq_pkg;

    localparam int PC_W_DEF      = 12;
    localparam int ADDR_W_DEF    = 16;
    localparam int SHIFT_DEF     = 2;
    localparam int RESET_PC_DEF  = 0;
    localparam int RAS_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        SEL_RESET,
        SEL_RET,
        SEL_JUMP,
        SEL_BRANCH,
        SEL_HOLD,
        SEL_INC
    } sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
// Sticky overflow/underflow flags clear only on rst.
module pc_ras
    import pc_seq_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH_DEF,
    parameter int W     = PC_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] push_data_i,
    output logic [W-1:0] top_data_o,
    output logic         empty_o,
    output logic         full_o,
    output logic         ovf_o,
    output logic         unf_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             do_push, do_pop;

    assign empty_o    = (cnt_q == '0);
    assign full_o     = (cnt_q == CNT_W'(DEPTH));
    assign top_data_o = mem_q[wr_ptr_q - PTR_W'(1)];
    assign ovf_o      = ovf_q;
    assign unf_o      = unf_q;

    // A pop request always wins over a simultaneous push.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & ~pop_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (pop_i) begin
            if (do_pop) begin
                wr_ptr_d = wr_ptr_q - PTR_W'(1);
                cnt_d    = cnt_q - CNT_W'(1);
            end else begin
                unf_d = 1'b1;
            end
        end else if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (full_o) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Entries are don't-care after reset, so the storage carries no reset.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with increment, branch, jump, stall and optional return stack.
// Return stack is present only when PC_SEQUENCER_RAS_EN is defined.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int SHIFT     = SHIFT_DEF,
    parameter int RESET_PC  = RESET_PC_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_i,
    input  logic [PC_W-1:0]   branch_off_i,
    input  logic              jump_i,
    input  logic [PC_W-1:0]   jump_tgt_i,
    input  logic              call_i,
    input  logic              ret_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [ADDR_W-1:0] real_pc_o,
    output logic              ras_ovf_o,
    output logic              ras_unf_o
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] ras_top;
    logic            ret_hit;
    logic            ret_miss;
    sel_e            sel;

    assign pc_inc = pc_q + PC_W'(1);

`ifdef PC_SEQUENCER_RAS_EN
    logic ras_empty;
    logic ras_full_unused;
    logic ras_push;

    // A return in the same cycle as a call performs only the return.
    assign ras_push = jump_i & call_i & ~ret_i;
    assign ret_hit  = ret_i & ~ras_empty;
    assign ret_miss = ret_i & ras_empty;

    pc_ras #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .push_i      (ras_push),
        .pop_i       (ret_i),
        .push_data_i (pc_inc),
        .top_data_o  (ras_top),
        .empty_o     (ras_empty),
        .full_o      (ras_full_unused),
        .ovf_o       (ras_ovf_o),
        .unf_o       (ras_unf_o)
    );
`else
    logic ras_cfg_unused;

    assign ras_cfg_unused = ^{ret_i, call_i, RAS_DEPTH[0]};
    assign ret_hit        = 1'b0;
    assign ret_miss       = 1'b0;
    assign ras_top        = '0;
    assign ras_ovf_o      = 1'b0;
    assign ras_unf_o      = 1'b0;
`endif

    always_comb begin
        sel = SEL_INC;
        if (rst) begin
            sel = SEL_RESET;
        end else if (ret_hit) begin
            sel = SEL_RET;
        end else if (ret_miss) begin
            // An empty-stack return swallows any lower-priority redirect.
            sel = stall_i ? SEL_HOLD : SEL_INC;
        end else if (jump_i) begin
            sel = SEL_JUMP;
        end else if (branch_i) begin
            sel = SEL_BRANCH;
        end else if (stall_i) begin
            sel = SEL_HOLD;
        end
    end

    always_comb begin
        pc_d = pc_q;
        case (sel)
            SEL_RESET:  pc_d = PC_W'(RESET_PC);
            SEL_RET:    pc_d = ras_top;
            SEL_JUMP:   pc_d = jump_tgt_i;
            SEL_BRANCH: pc_d = pc_q + branch_off_i;
            SEL_HOLD:   pc_d = pc_q;
            SEL_INC:    pc_d = pc_inc;
            default:    pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= PC_W'(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o      = pc_q;
    assign real_pc_o = ADDR_W'(pc_q) << SHIFT;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer against a queue-based behavioural model.
// Return-stack scenarios are selected by PC_SEQUENCER_RAS_EN, matching the DUT build.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [11:0] branch_off_i = '0;
    logic        jump_i = 1'b0;
    logic [11:0] jump_tgt_i = '0;
    logic        call_i = 1'b0;
    logic        ret_i = 1'b0;
    logic [11:0] pc_o;
    logic [15:0] real_pc_o;
    logic        ras_ovf_o;
    logic        ras_unf_o;

    int errors = 0;
    int checks = 0;

    int m_pc = 0;
    int m_stk[$];
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .branch_i     (branch_i),
        .branch_off_i (branch_off_i),
        .jump_i       (jump_i),
        .jump_tgt_i   (jump_tgt_i),
        .call_i       (call_i),
        .ret_i        (ret_i),
        .pc_o         (pc_o),
        .real_pc_o    (real_pc_o),
        .ras_ovf_o    (ras_ovf_o),
        .ras_unf_o    (ras_unf_o)
    );

    // Reference behaviour: priority rst > ret > jump > branch > stall > increment.
    task automatic model_step(input bit r, input bit st, input bit br, input int off,
                              input bit j, input int tgt, input bit c, input bit rt);
        if (r) begin
            m_pc = 0;
            m_stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            return;
        end
`ifdef PC_SEQUENCER_RAS_EN
        if (rt) begin
            if (m_stk.size() > 0) begin
                m_pc = m_stk.pop_back();
            end else begin
                m_unf = 1'b1;
                if (!st) m_pc = (m_pc + 1) % 4096;
            end
            return;
        end
`endif
        if (j) begin
`ifdef PC_SEQUENCER_RAS_EN
            if (c) begin
                if (m_stk.size() == 4) begin
                    void'(m_stk.pop_front());
                    m_ovf = 1'b1;
                end
                m_stk.push_back((m_pc + 1) % 4096);
            end
`endif
            m_pc = tgt;
        end else if (br) begin
            m_pc = (m_pc + off) % 4096;
        end else if (!st) begin
            m_pc = (m_pc + 1) % 4096;
        end
    endtask

    task automatic drive(input bit r, input bit st, input bit br, input logic [11:0] off,
                         input bit j, input logic [11:0] tgt, input bit c, input bit rt);
        rst = r; stall_i = st; branch_i = br; branch_off_i = off;
        jump_i = j; jump_tgt_i = tgt; call_i = c; ret_i = rt;
        model_step(r, st, br, int'(off), j, int'(tgt), c, rt);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 1, 12'h123, 1, 12'h555, 1, 1);
        if (pc_o !== 12'h000) begin errors++; $display("FAIL reset_pc got=%h exp=000", pc_o); end
        checks++;
        if (real_pc_o !== 16'h0000) begin errors++; $display("FAIL reset_real got=%h exp=0000", real_pc_o); end
        checks++;
        if ({ras_ovf_o, ras_unf_o} !== 2'b00) begin
            errors++; $display("FAIL reset_flags got=%b%b exp=00", ras_ovf_o, ras_unf_o);
        end
        checks++;
    endtask

    task automatic test_increment();
        for (int i = 1; i <= 3; i++) begin
            drive(0, 0, 0, 12'h0, 0, 12'h0, 0, 0);
            if (pc_o !== 12'(i)) begin errors++; $display("FAIL inc_pc got=%h exp=%h", pc_o, 12'(i)); end
            checks++;
            if (real_pc_o !== 16'(i * 4)) begin
                errors++; $display("FAIL inc_real got=%h exp=%h", real_pc_o, 16'(i * 4));
            end
            checks++;
        end
    endtask

    task automatic test_wrap();
        drive(0, 0, 0, 12'h0, 1, 12'hFFF, 0, 0);
        if (pc_o !== 12'hFFF) begin errors++; $display("FAIL wrap_jump got=%h exp=fff", pc_o); end
        checks++;
        drive(0, 0, 0, 12'h0, 0, 12'h0, 0, 0);
        if (pc_o !== 12'h000) begin errors++; $display("FAIL wrap_pc got=%h exp=000", pc_o); end
        checks++;
        if (real_pc_o !== 16'h0000) begin errors++; $display("FAIL wrap_real got=%h exp=0000", real_pc_o); end
        checks++;
    endtask

    task automatic test_branch_stall();
        drive(0, 0, 0, 12'h0, 1, 12'h010, 0, 0);
        drive(0, 1, 1, 12'hFFD, 0, 12'h0, 0, 0);
        if (pc_o !== 12'h00D) begin errors++; $display("FAIL branch_neg got=%h exp=00d", pc_o); end
        checks++;
        drive(0, 1, 0, 12'h0, 0, 12'h0, 0, 0);
        if (pc_o !== 12'h00D) begin errors++; $display("FAIL stall_hold got=%h exp=00d", pc_o); end
        checks++;
        drive(0, 0, 1, 12'h7F0, 1, 12'h444, 0, 0);
        if (pc_o !== 12'h444) begin errors++; $display("FAIL jump_over_branch got=%h exp=444", pc_o); end
        checks++;
        drive(0, 0, 0, 12'h0, 0, 12'h0, 0, 0);
        if (pc_o !== 12'h445) begin errors++; $display("FAIL branch_dropped got=%h exp=445", pc_o); end
        checks++;
    endtask

`ifdef PC_SEQUENCER_RAS_EN
    task automatic test_call_ret();
        logic [11:0] exp_ret [4];
        exp_ret = '{12'h331, 12'h321, 12'h311, 12'h301};
        drive(1, 0, 0, 12'h0, 0, 12'h0, 0, 0);
        drive(0, 0, 0, 12'h0, 1, 12'h100, 0, 0);
        drive(0, 0, 0, 12'h0, 1, 12'hABC, 1, 0);
        if (pc_o !== 12'hABC) begin errors++; $display("FAIL call_pc got=%h exp=abc", pc_o); end
        checks++;
        drive(0, 0, 0, 12'h0, 0, 12'h0, 0, 1);
        if (pc_o !== 12'h101) begin errors++; $display("FAIL ret_pc got=%h exp=101", pc_o); end
        checks++;
        drive(0, 0, 0, 12'h0, 1, 12'h200, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 12'h0, 1, 12'(12'h300 + 16 * i), 1, 0);
            if (ras_ovf_o !== (i == 4)) begin
                errors++; $display("FAIL ovf_call%0d got=%b exp=%b", i, ras_ovf_o, (i == 4));
            end
            checks++;
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 12'h0, 0, 12'h0, 0, 1);
            if (pc_o !== exp_ret[i]) begin
                errors++; $display("FAIL ret%0d_pc got=%h exp=%h", i, pc_o, exp_ret[i]);
            end
            checks++;
            if (ras_unf_o !== 1'b0) begin errors++; $display("FAIL ret%0d_unf got=%b exp=0", i, ras_unf_o); end
            checks++;
        end
        drive(0, 0, 0, 12'h0, 0, 12'h0, 0, 1);
        if (pc_o !== 12'h302) begin errors++; $display("FAIL unf_pc got=%h exp=302", pc_o); end
        checks++;
        if ({ras_ovf_o, ras_unf_o} !== 2'b11) begin
            errors++; $display("FAIL unf_flags got=%b%b exp=11", ras_ovf_o, ras_unf_o);
        end
        checks++;
    endtask
`else
    task automatic test_call_ret();
        drive(0, 0, 0, 12'h0, 1, 12'h100, 0, 0);
        drive(0, 0, 0, 12'h0, 1, 12'hABC, 1, 0);
        if (pc_o !== 12'hABC) begin errors++; $display("FAIL call_as_jump got=%h exp=abc", pc_o); end
        checks++;
        drive(0, 0, 0, 12'h0, 0, 12'h0, 0, 1);
        if (pc_o !== 12'hABD) begin errors++; $display("FAIL ret_ignored got=%h exp=abd", pc_o); end
        checks++;
        drive(0, 0, 0, 12'h0, 1, 12'h222, 0, 1);
        if (pc_o !== 12'h222) begin errors++; $display("FAIL ret_jump got=%h exp=222", pc_o); end
        checks++;
        if ({ras_ovf_o, ras_unf_o} !== 2'b00) begin
            errors++; $display("FAIL noras_flags got=%b%b exp=00", ras_ovf_o, ras_unf_o);
        end
        checks++;
    endtask
`endif

    task automatic test_random();
        bit r, st, br, j, c, rt;
        for (int n = 0; n < 600; n++) begin
            r  = ($urandom_range(0, 79) == 0);
            st = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 3) == 0);
            j  = ($urandom_range(0, 4) == 0);
            c  = ($urandom_range(0, 1) == 0);
            rt = ($urandom_range(0, 5) == 0);
            drive(r, st, br, 12'($urandom), j, 12'($urandom), c, rt);
            if (pc_o !== 12'(m_pc)) begin
                errors++; $display("FAIL rand%0d_pc got=%h exp=%h", n, pc_o, 12'(m_pc));
            end
            checks++;
            if (real_pc_o !== 16'(m_pc * 4)) begin
                errors++; $display("FAIL rand%0d_real got=%h exp=%h", n, real_pc_o, 16'(m_pc * 4));
            end
            checks++;
            if ({ras_ovf_o, ras_unf_o} !== {m_ovf, m_unf}) begin
                errors++; $display("FAIL rand%0d_flags got=%b%b exp=%b%b", n, ras_ovf_o, ras_unf_o, m_ovf, m_unf);
            end
            checks++;
        end
    endtask

    task automatic test_reset_override();
        drive(0, 0, 0, 12'h0, 1, 12'h0F0, 0, 0);
        drive(0, 0, 0, 12'h0, 0, 12'h0, 0, 1);
        drive(1, 1, 1, 12'h010, 1, 12'h555, 1, 0);
        if (pc_o !== 12'h000) begin errors++; $display("FAIL rst_over_jump got=%h exp=000", pc_o); end
        checks++;
        if ({ras_ovf_o, ras_unf_o} !== 2'b00) begin
            errors++; $display("FAIL rst_clears_flags got=%b%b exp=00", ras_ovf_o, ras_unf_o);
        end
        checks++;
        drive(0, 0, 0, 12'h0, 0, 12'h0, 0, 0);
        if (pc_o !== 12'h001) begin errors++; $display("FAIL after_rst got=%h exp=001", pc_o); end
        checks++;
    endtask

    initial begin
        test_reset();
        test_increment();
        test_wrap();
        test_branch_stall();
        test_call_ret();
        test_random();
        test_reset_override();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 12, meaning word-address PC width.
REQ-002 SHALL have parameter ADDR_W, default 16, meaning byte-address output width; ADDR_W >= PC_W + SHIFT.
REQ-003 SHALL have parameter SHIFT, default 2, meaning log2 of bytes per instruction word.
REQ-004 SHALL have parameter RESET_PC, default 0, meaning PC_W-bit word address loaded on reset.
REQ-005 SHALL have parameter RAS_DEPTH, default 4, meaning return-stack entries, power of two, at least 2.
REQ-006 SHALL use one clock; reset is synchronous and active-high: clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 stall_i  in  1  hold PC when no redirect is pending.
REQ-009 branch_i  in  1  PC-relative redirect request.
REQ-010 branch_off_i  in  PC_W  signed word offset, relative to current pc_o.
REQ-011 jump_i  in  1  absolute redirect request.
REQ-012 jump_tgt_i  in  PC_W  absolute word target.
REQ-013 call_i  in  1  qualifies jump_i as a call; ignored without jump_i.
REQ-014 ret_i  in  1  return to top of return stack.
REQ-015 pc_o  out  PC_W  registered word PC.
REQ-016 real_pc_o  out  ADDR_W  zero-extended {pc_o, SHIFT zeros}, combinational from pc_o.
REQ-017 ras_ovf_o  out  1  sticky return-stack overflow flag.
REQ-018 ras_unf_o  out  1  sticky return-stack underflow flag.

Function
REQ-019 The next-PC priority SHALL be: rst > ret_i > jump_i > branch_i > stall_i > increment.
REQ-020 The increment SHALL set pc_o to pc_o+1 modulo 2^PC_W; 2^PC_W-1 wraps to 0.
REQ-021 A branch SHALL set pc_o to pc_o+branch_off_i modulo 2^PC_W, using two's-complement arithmetic.
REQ-022 A jump SHALL set pc_o to jump_tgt_i.
REQ-023 Every redirect SHALL take effect on the next rising edge (1-cycle latency) and SHALL override stall_i.
REQ-024 A redirect SHALL NOT be buffered: a redirect that loses priority in a cycle is dropped.
REQ-025 With stall_i=1 and no redirect, pc_o SHALL hold its value.
REQ-026 jump_i&call_i SHALL push pc_o+1 (wrapped) onto the return stack.
REQ-027 ret_i with a non-empty stack SHALL pop, and load pc_o from the popped entry.
REQ-028 ret_i with an empty stack SHALL increment pc_o as normal (stall_i still applies), SHALL leave the stack unchanged, and SHALL set ras_unf_o.
REQ-029 A push to a full stack SHALL discard the oldest entry (circular), SHALL keep the count at RAS_DEPTH, and SHALL set ras_ovf_o.
REQ-030 ret_i together with jump_i&call_i SHALL perform only the return; the call is dropped.
REQ-031 Flags SHALL stay set until rst.

Reset
REQ-032 On rst, pc_o SHALL be set to RESET_PC, the stack count SHALL be set to 0, and ras_ovf_o and ras_unf_o SHALL be set to 0; stack entries are don't-care.
REQ-033 rst SHALL override any concurrent redirect, call or return, in the same edge.

Configuration
REQ-034 With macro PC_SEQUENCER_RAS_EN defined, the return stack and flags SHALL behave as specified above.
REQ-035 Without PC_SEQUENCER_RAS_EN, there SHALL be no stack storage; ret_i and call_i SHALL be ignored (a call then acts as a plain jump); ras_ovf_o and ras_unf_o SHALL be tied to 0.

Structure
REQ-036 A shared package pc_seq_pkg SHALL hold the next-PC select enum (SEL_RESET, SEL_RET, SEL_JUMP, SEL_BRANCH, SEL_HOLD, SEL_INC) and the default parameter constants.
REQ-037 The return stack SHALL be a sub-module pc_ras with ports push, pop, push data, top data, empty, full, and flags.
REQ-038 The byte-address shift SHALL be combinational inside pc_sequencer.

Verification
REQ-039 Reset then 3 idle cycles -> pc_o=0,1,2,3 and real_pc_o=0x0000,0x0004,0x0008,0x000C.
REQ-040 pc_o=0xFFF, no stall -> pc_o=0x000 and real_pc_o=0x0000 next cycle.
REQ-041 pc_o=0x010, stall_i=1, branch_i=1, offset=-3 (0xFFD) -> pc_o=0x00D; next cycle stall only -> pc_o holds 0x00D.
REQ-042 (RAS_EN) pc_o=0x100, jump_i+call_i to 0xABC, then ret_i -> pc_o=0xABC then 0x101.
REQ-043 (RAS_EN) five calls with RAS_DEPTH=4 -> ras_ovf_o=1; then five returns -> four correct addresses, the fifth sets ras_unf_o=1 and pc_o increments.
REQ-044 rst asserted with jump_i=1, jump_tgt_i=0x555 -> pc_o=RESET_PC and flags cleared.
